// File: rtl/window_morph3x3.sv
// window_morph3x3: 3x3 binary erode/dilate stage with frame position tracking.
// A pixel counts as foreground when any of its N bits is set. Results on the
// frame border are forced to 0.
// Optional feature macro: WINDOW_MORPH_AREA_EN adds a per-frame count of
// po=1 results, published on 'area' with frame_end. Without the macro,
// 'area' is tied to 0.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for the first window of a frame; geometry taken live
// ACTIVE | mid-frame; geometry and mode come from the values latched at start
module window_morph3x3 #(
    parameter int N = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [15:0]  width,
    input  logic [15:0]  height,
    input  logic         mode,
    input  logic [N-1:0] pi00,
    input  logic [N-1:0] pi01,
    input  logic [N-1:0] pi02,
    input  logic [N-1:0] pi10,
    input  logic [N-1:0] pi11,
    input  logic [N-1:0] pi12,
    input  logic [N-1:0] pi20,
    input  logic [N-1:0] pi21,
    input  logic [N-1:0] pi22,
    input  logic         valid_in,
    output logic         po,
    output logic         valid_out,
    output logic [15:0]  x,
    output logic [15:0]  y,
    output logic         frame_end,
    output logic [31:0]  area
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t      state;
    logic [15:0] w_lat;
    logic [15:0] h_lat;
    logic        mode_lat;
    logic [15:0] col;
    logic [15:0] row;

    logic [15:0] cur_w;
    logic [15:0] cur_h;
    logic [15:0] cur_x;
    logic [15:0] cur_y;
    logic        cur_mode;
    logic        start;
    logic        accept;
    logic        at_col_end;
    logic        at_row_end;
    logic        last;
    logic        border;
    logic        po_next;
    logic [8:0]  fg;

    assign fg = {|pi22, |pi21, |pi20, |pi12, |pi11, |pi10, |pi02, |pi01, |pi00};

    // A zero-sized frame is never started; the window is simply dropped.
    assign start  = (state == IDLE) && valid_in && (width != 16'd0) && (height != 16'd0);
    assign accept = start || ((state == ACTIVE) && valid_in);

    // The first window of a frame uses the live geometry, later ones the latched copy.
    always_comb begin
        cur_w    = w_lat;
        cur_h    = h_lat;
        cur_mode = mode_lat;
        cur_x    = col;
        cur_y    = row;
        if (state == IDLE) begin
            cur_w    = width;
            cur_h    = height;
            cur_mode = mode;
            cur_x    = 16'd0;
            cur_y    = 16'd0;
        end
    end

    assign at_col_end = (cur_x == cur_w - 16'd1);
    assign at_row_end = (cur_y == cur_h - 16'd1);
    assign last       = at_col_end && at_row_end;
    assign border     = (cur_x == 16'd0) || at_col_end || (cur_y == 16'd0) || at_row_end;
    assign po_next    = border ? 1'b0 : (cur_mode ? (|fg) : (&fg));

    // Frame FSM: latch geometry at start, advance position per accepted window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            w_lat    <= 16'd0;
            h_lat    <= 16'd0;
            mode_lat <= 1'b0;
            col      <= 16'd0;
            row      <= 16'd0;
        end else if (accept) begin
            if (start) begin
                w_lat    <= width;
                h_lat    <= height;
                mode_lat <= mode;
            end
            if (last) begin
                state <= IDLE;
                col   <= 16'd0;
                row   <= 16'd0;
            end else begin
                state <= ACTIVE;
                if (at_col_end) begin
                    col <= 16'd0;
                    row <= cur_y + 16'd1;
                end else begin
                    col <= cur_x + 16'd1;
                    row <= cur_y;
                end
            end
        end
    end

    // Registered result: one output cycle per accepted window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            po        <= 1'b0;
            valid_out <= 1'b0;
            x         <= 16'd0;
            y         <= 16'd0;
            frame_end <= 1'b0;
        end else begin
            valid_out <= accept;
            frame_end <= accept && last;
            if (accept) begin
                po <= po_next;
                x  <= cur_x;
                y  <= cur_y;
            end
        end
    end

`ifdef WINDOW_MORPH_AREA_EN
    logic [31:0] area_cnt;

    // Running foreground count; published and cleared on the last window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            area_cnt <= 32'd0;
            area     <= 32'd0;
        end else if (accept) begin
            if (last) begin
                area     <= area_cnt + {31'd0, po_next};
                area_cnt <= 32'd0;
            end else begin
                area_cnt <= area_cnt + {31'd0, po_next};
            end
        end
    end
`else
    assign area = 32'd0;
`endif

endmodule

// File: doc/window_morph3x3.md
WINDOW_MORPH3X3 -- requirements
Module: window_morph3x3

Interface
REQ-001 Parameter N, default 1: bit width of each window pixel; a pixel is foreground when nonzero.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 width  input  16  frame width in pixels, sampled at frame start.
REQ-005 height  input  16  frame height in lines, sampled at frame start.
REQ-006 mode  input  1  0 = erode (AND of 9 pixels), 1 = dilate (OR of 9 pixels); sampled at frame start.
REQ-007 pi00..pi22  input  N each  3x3 window from the line-buffer block; pi11 is the centre pixel.
REQ-008 valid_in  input  1  window valid strobe, one window per asserted cycle.
REQ-009 po  output  1  morphology result for the current window.
REQ-010 valid_out  output  1  po, x and y valid.
REQ-011 x  output  16  column of the result (0..width-1).
REQ-012 y  output  16  row of the result (0..height-1).
REQ-013 frame_end  output  1  one-cycle pulse coincident with the last result of a frame.
REQ-014 area  output  32  count of po=1 results in the last completed frame.

Function
REQ-015 The FSM SHALL have two states, IDLE and ACTIVE.
REQ-016 In IDLE, valid_in=1 with width>=1 and height>=1 SHALL latch width, height and mode, process that window as x=0,y=0, and enter ACTIVE.
REQ-017 In IDLE, valid_in=1 with width=0 or height=0 SHALL be ignored; the block stays in IDLE and no output is produced.
REQ-018 Each valid_in SHALL produce exactly one registered result, with valid_out asserted exactly 1 cycle later.
REQ-019 valid_out SHALL be 0 on every cycle that does not follow a valid_in cycle; gaps in valid_in SHALL be tolerated without losing position.
REQ-020 For each result, x SHALL increment and wrap to 0 at latched width-1; on wrap, y SHALL increment.
REQ-021 Border results SHALL force po=0: x=0, x=width-1, y=0 or y=height-1.
REQ-022 Interior results SHALL use po = AND of the nine foreground bits in erode mode and OR of the nine in dilate mode.
REQ-023 The result at x=width-1, y=height-1 SHALL assert frame_end with its valid_out, and the FSM SHALL return to IDLE.
REQ-024 A valid_in on the cycle after frame_end SHALL start a new frame with no dead cycle.
REQ-025 Changes to width, height or mode during ACTIVE SHALL have no effect until the next frame start.
REQ-026 width=1 or height=1 SHALL yield all-border frames, so every po is 0.

Reset
REQ-027 Asserting reset_n low SHALL immediately force IDLE, po=0, valid_out=0, x=0, y=0, frame_end=0 and area=0, including mid-frame.
REQ-028 After release, the next valid_in SHALL be treated as the first pixel of a new frame.

Configuration
REQ-029 Macro WINDOW_MORPH_AREA_EN, when defined, SHALL compile in a 32-bit running counter of po=1 results; the counter is copied to area on the frame_end cycle and cleared for the next frame.
REQ-030 When WINDOW_MORPH_AREA_EN is undefined, the counter SHALL be absent and area SHALL be held at constant 0.

Verification
REQ-031 width=8, height=8, mode=0, all windows all-ones, continuous valid_in -> 64 valid_out pulses, 36 with po=1 (x,y in 1..6); frame_end at x=7,y=7; area=36 if the macro is defined, else 0.
REQ-032 Same frame with mode=1 and only the centre pixel set in each window -> 36 po=1 results, all border results 0.
REQ-033 width=8, height=8 with valid_in toggling every cycle -> 64 results, x,y sequence unbroken, each valid_out exactly 1 cycle after its valid_in.
REQ-034 width changed from 8 to 4 at y=3 -> the current frame continues with width 8; the next frame wraps x at 3.
REQ-035 reset_n pulsed low at x=5,y=2 -> outputs zero asynchronously; the next valid_in yields x=0,y=0.
REQ-036 width=0 with valid_in high -> valid_out stays 0 and the FSM remains IDLE.
